// File: rtl/cos_seq_pkg.sv
// Shared constants and types for the cosine sweep sequencer.
package cos_seq_pkg;

  localparam logic [31:0] COS_CTRL_ADDR = 32'h0000_0020;
  localparam logic [31:0] COS_DATA_ADDR = 32'h0000_0024;
  localparam logic [31:0] COS_STAT_ADDR = 32'h0000_0028;
  localparam int          COS_START_BIT = 7;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLVERR  = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WR_CTRL = 3'd2,
    S_POLL    = 3'd3,
    S_RD_DATA = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } seq_state_e;

endpackage

// File: rtl/apb_xfer_engine.sv
// Single APB transfer: SETUP, ACCESS until PREADY, then back to idle (PSEL low).
module apb_xfer_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_slverr,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  localparam logic [1:0] E_IDLE   = 2'd0;
  localparam logic [1:0] E_SETUP  = 2'd1;
  localparam logic [1:0] E_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Requests are only taken in E_IDLE, which guarantees the PSEL-low gap cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= E_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        E_IDLE: if (i_req) begin
          r_write <= i_write;
          r_addr  <= i_addr;
          r_wdata <= i_wdata;
          r_state <= E_SETUP;
        end
        E_SETUP:  r_state <= E_ACCESS;
        E_ACCESS: if (i_pready) r_state <= E_IDLE;
        default:  r_state <= E_IDLE;
      endcase
    end
  end

  assign o_psel    = (r_state == E_SETUP) || (r_state == E_ACCESS);
  assign o_penable = (r_state == E_ACCESS);
  assign o_pwrite  = r_write;
  assign o_paddr   = r_addr;
  assign o_pwdata  = r_wdata;
  assign o_ack     = (r_state == E_ACCESS) && i_pready;
  assign o_rdata   = i_prdata;
  assign o_slverr  = i_pslverr;

endmodule

// File: rtl/cos_sweep_sequencer.sv
// Sweeps the apb_slave cosine engine over an index range into an 8-entry buffer.
// Optional sticky interrupt (irq/irq_clr) enabled with `define COS_SEQ_IRQ_EN.
module cos_sweep_sequencer
  import cos_seq_pkg::*;
#(
  parameter int POLL_MAX = 16,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              start,
  input  logic [2:0]        first_idx,
  input  logic [2:0]        last_idx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  input  logic [2:0]        res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic [7:0]        res_valid,
`ifdef COS_SEQ_IRQ_EN
  output logic              irq,
  input  logic              irq_clr,
`endif
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  seq_state_e        r_state;
  err_code_e         r_err;
  logic [2:0]        r_first;
  logic [2:0]        r_last;
  logic [2:0]        r_idx;
  logic [CNT_W-1:0]  r_poll_cnt;
  logic [7:0]        r_valid;
  logic [DATA_W-1:0] r_buf [8];

  logic              w_xfer;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_ack;
  logic              w_slverr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_to_err;
  logic              w_to_done;
  err_code_e         w_err_next;

  apb_xfer_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_xfer (
    .i_clk     (PCLK),
    .i_rst     (PRESET),
    .i_req     (w_xfer),
    .i_write   (w_write),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .o_ack     (w_ack),
    .o_rdata   (w_rdata),
    .o_slverr  (w_slverr),
    .o_psel    (PSEL),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE),
    .o_paddr   (PADDR),
    .o_pwdata  (PWDATA),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR)
  );

  always_comb begin
    w_xfer     = (r_state == S_WR_CTRL) || (r_state == S_POLL) || (r_state == S_RD_DATA);
    w_write    = (r_state == S_WR_CTRL);
    w_addr     = ADDR_W'(COS_DATA_ADDR);
    if (r_state == S_WR_CTRL) w_addr = ADDR_W'(COS_CTRL_ADDR);
    if (r_state == S_POLL)    w_addr = ADDR_W'(COS_STAT_ADDR);
    w_wdata                = '0;
    w_wdata[COS_START_BIT] = 1'b1;
    w_wdata[2:0]           = r_idx;
    // Error priority: range check, then bus error, then poll timeout.
    w_to_err   = 1'b0;
    w_err_next = ERR_NONE;
    if (r_state == S_CHECK && r_first > r_last) begin
      w_to_err   = 1'b1;
      w_err_next = ERR_RANGE;
    end else if (w_xfer && w_ack && w_slverr) begin
      w_to_err   = 1'b1;
      w_err_next = ERR_SLVERR;
    end else if (r_state == S_POLL && w_ack && !w_rdata[0] &&
                 r_poll_cnt == CNT_W'(POLL_MAX - 1)) begin
      w_to_err   = 1'b1;
      w_err_next = ERR_TIMEOUT;
    end
    w_to_done = (r_state == S_NEXT) && (r_idx == r_last);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= S_IDLE;
      r_err      <= ERR_NONE;
      r_first    <= '0;
      r_last     <= '0;
      r_idx      <= '0;
      r_poll_cnt <= '0;
      r_valid    <= '0;
    end else if (w_to_err) begin
      r_state <= S_ERR;
      r_err   <= w_err_next;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          r_first <= first_idx;
          r_last  <= last_idx;
          r_err   <= ERR_NONE;
          r_valid <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_idx   <= r_first;
          r_state <= S_WR_CTRL;
        end
        S_WR_CTRL: if (w_ack) begin
          r_poll_cnt <= '0;
          r_state    <= S_POLL;
        end
        S_POLL: if (w_ack) begin
          if (w_rdata[0]) r_state <= S_RD_DATA;
          else            r_poll_cnt <= r_poll_cnt + CNT_W'(1);
        end
        S_RD_DATA: if (w_ack) begin
          r_valid[r_idx] <= 1'b1;
          r_state        <= S_NEXT;
        end
        S_NEXT: begin
          if (w_to_done) r_state <= S_DONE;
          else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_WR_CTRL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result storage carries no reset; res_valid qualifies every entry.
  always_ff @(posedge PCLK) begin
    if (r_state == S_RD_DATA && w_ack && !w_slverr) r_buf[r_idx] <= w_rdata;
  end

`ifdef COS_SEQ_IRQ_EN
  logic r_irq;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                    r_irq <= 1'b0;
    else if (w_to_err || w_to_done) r_irq <= 1'b1;
    else if (irq_clr)              r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

  assign busy      = (r_state == S_CHECK) || w_xfer || (r_state == S_NEXT);
  assign done      = (r_state == S_DONE);
  assign err_code  = r_err;
  assign res_valid = r_valid;
  assign res_data  = r_valid[res_idx] ? r_buf[res_idx] : '0;

endmodule

// File: tb/tb_cos_sweep_sequencer.sv
// Scoreboard bench for cos_sweep_sequencer with a behavioural APB cosine slave.
module tb_cos_sweep_sequencer;

  localparam int POLL_MAX = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  first_idx = 3'd0;
  logic [2:0]  last_idx = 3'd0;
  logic [2:0]  res_idx = 3'd0;
  logic        busy, done;
  logic [1:0]  err_code;
  logic [31:0] res_data;
  logic [7:0]  res_valid;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
`ifdef COS_SEQ_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  cos_sweep_sequencer #(.POLL_MAX(POLL_MAX), .ADDR_W(32), .DATA_W(32)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .busy      (busy),
    .done      (done),
    .err_code  (err_code),
    .res_idx   (res_idx),
    .res_data  (res_data),
    .res_valid (res_valid),
`ifdef COS_SEQ_IRQ_EN
    .irq       (irq),
    .irq_clr   (irq_clr),
`endif
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic             done;
    logic [1:0]       err;
    logic [7:0]       valid;
    logic [7:0][31:0] bufv;
  } end_t;

  xfer_t exp_x[$];
  end_t  exp_e[$];

  int n_tests = 0;
  int n_fail = 0;
  int end_count = 0;

  int         cfg_polls = 1;
  int         cfg_wait = 0;
  int         cfg_err_at = 0;
  int         sl_xfer_no = 0;
  int         sl_poll_k = 0;
  int         sl_wait_cnt = 0;
  logic [2:0] sl_angle = 3'd0;

  function automatic logic [31:0] cos_ref(input logic [2:0] i);
    case (i)
      3'd0:    return 32'h0000_7FFF;
      3'd1:    return 32'h0000_7642;
      3'd2:    return 32'h0000_5A82;
      3'd3:    return 32'h0000_30FC;
      3'd4:    return 32'h0000_0000;
      3'd5:    return 32'hFFFF_CF04;
      3'd6:    return 32'hFFFF_A57E;
      default: return 32'hFFFF_89BE;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_x(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
    xfer_t x;
    x.addr = addr; x.write = write; x.wdata = wdata;
    exp_x.push_back(x);
  endtask

  // Reference: the transfer list and final outcome implied by the sweep rules.
  task automatic model(input int f, input int l, input int polls, input int err_at);
    end_t e;
    int   n;
    bit   stop;
    e = '0; n = 0; stop = 0;
    if (f > l) begin
      e.err = 2'd2;
      exp_e.push_back(e);
      return;
    end
    for (int i = f; i <= l && !stop; i++) begin
      int np;
      n++;
      push_x(32'h20, 1'b1, 32'h80 + 32'(i));
      if (n == err_at) begin e.err = 2'd1; stop = 1; end
      np = (polls == 0) ? POLL_MAX : polls;
      for (int k = 0; k < np && !stop; k++) begin
        n++;
        push_x(32'h28, 1'b0, 32'h0);
        if (n == err_at) begin e.err = 2'd1; stop = 1; end
      end
      if (!stop && polls == 0) begin e.err = 2'd3; stop = 1; end
      if (!stop) begin
        n++;
        push_x(32'h24, 1'b0, 32'h0);
        if (n == err_at) begin
          e.err = 2'd1; stop = 1;
        end else begin
          e.valid[i] = 1'b1;
          e.bufv[i]  = cos_ref(3'(i));
        end
      end
    end
    if (!stop) e.done = 1'b1;
    exp_e.push_back(e);
  endtask

  // APB slave + transfer scoreboard.
  initial begin : slave
    logic        prev_cmpl;
    logic        stable;
    logic [31:0] s_addr, s_wdata;
    xfer_t       e;
    prev_cmpl = 1'b0; stable = 1'b1; s_addr = '0; s_wdata = '0;
    forever begin
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'd0;
      if (PRESET) begin
        sl_wait_cnt = 0;
        prev_cmpl = 1'b0;
      end else begin
        if (prev_cmpl) check("idle_gap_psel", 32'(PSEL), 32'd0);
        prev_cmpl = 1'b0;
        if (PSEL && !PENABLE) begin
          s_addr = PADDR; s_wdata = PWDATA; stable = 1'b1; sl_wait_cnt = 0;
        end else if (PSEL && PENABLE) begin
          if (PADDR !== s_addr || PWDATA !== s_wdata) stable = 1'b0;
          if (sl_wait_cnt < cfg_wait) sl_wait_cnt++;
          else begin
            PREADY = 1'b1;
            sl_xfer_no++;
            PSLVERR = (sl_xfer_no == cfg_err_at);
            if (PWRITE) begin
              if (PADDR == 32'h20) begin sl_angle = PWDATA[2:0]; sl_poll_k = 0; end
            end else if (PADDR == 32'h28) begin
              sl_poll_k++;
              PRDATA = 32'(cfg_polls != 0 && sl_poll_k >= cfg_polls);
            end else if (PADDR == 32'h24) begin
              PRDATA = cos_ref(sl_angle);
            end
            if (exp_x.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL xfer_unexpected: got addr 0x%0h write %0d, expected none", PADDR, PWRITE);
            end else begin
              e = exp_x.pop_front();
              check("xfer_addr", PADDR, e.addr);
              check("xfer_write", 32'(PWRITE), 32'(e.write));
              if (e.write) check("xfer_wdata", PWDATA, e.wdata);
            end
            check("xfer_stable", 32'(stable), 32'd1);
            prev_cmpl = 1'b1;
          end
        end
      end
    end
  end

  // End-of-sweep scoreboard: fires when busy falls.
  initial begin : endmon
    logic prev_busy;
    end_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge PCLK);
      if (prev_busy && !busy) begin
        if (exp_e.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL end_unexpected: got done %0d err %0d, expected no sweep end", done, err_code);
        end else begin
          e = exp_e.pop_front();
          check("end_done", 32'(done), 32'(e.done));
          check("end_err_code", 32'(err_code), 32'(e.err));
          check("end_res_valid", 32'(res_valid), 32'(e.valid));
          check("end_psel", 32'(PSEL), 32'd0);
          check("end_xfer_missing", 32'(exp_x.size()), 32'd0);
          exp_x.delete();
          for (int i = 0; i < 8; i++) begin
            if (e.valid[i]) begin
              res_idx = 3'(i);
              #1;
              check("res_data", res_data, e.bufv[i]);
            end
          end
        end
        end_count++;
      end
      prev_busy = busy;
    end
  end

  task automatic run_sweep(input int f, input int l, input int polls, input int wt,
                           input int err_at, input int repulse);
    int ec, cyc;
    cfg_polls = polls; cfg_wait = wt; cfg_err_at = err_at; sl_xfer_no = 0;
    model(f, l, polls, err_at);
    @(negedge PCLK);
    first_idx = f[2:0]; last_idx = l[2:0]; start = 1'b1;
    ec = end_count;
    @(negedge PCLK);
    start = 1'b0;
    first_idx = 3'($urandom_range(0, 7)); last_idx = 3'($urandom_range(0, 7));
    cyc = 0;
    while (end_count == ec && cyc < 5000) begin
      @(negedge PCLK);
      cyc++;
      start = (repulse != 0 && cyc == repulse);
    end
    start = 1'b0;
    if (end_count == ec) begin
      n_tests++; n_fail++;
      $display("FAIL sweep_timeout: got no sweep end after %0d cycles, expected one", cyc);
      exp_x.delete(); exp_e.delete();
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish, expected the run to end");
    $fatal(1);
  end

  initial begin : stim
    int cyc;
    repeat (3) @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_res_data", res_data, 32'd0);
`ifdef COS_SEQ_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    run_sweep(0, 7, 2, 0, 0, 0);   // full sweep
    run_sweep(3, 3, 2, 0, 0, 0);   // single angle
`ifdef COS_SEQ_IRQ_EN
    check("irq_set_done", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    @(negedge PCLK);
    irq_clr = 1'b0;
    check("irq_cleared", 32'(irq), 32'd0);
`endif
    run_sweep(5, 2, 2, 0, 0, 0);   // bad range
    run_sweep(0, 7, 1, 0, 3, 0);   // PSLVERR on first data read
    run_sweep(2, 4, 0, 0, 0, 0);   // status stuck: poll timeout
    run_sweep(1, 4, 1, 3, 0, 10);  // wait states + ignored start
    for (int t = 0; t < 10; t++) begin
      int f, l, p, w, ea;
      f  = int'($urandom_range(0, 7));
      l  = int'($urandom_range(0, 7));
      p  = int'($urandom_range(1, 3));
      w  = int'($urandom_range(0, 2));
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_sweep(f, l, p, w, ea, 0);
    end

    // Reset during a stalled ACCESS phase.
    cfg_polls = 1; cfg_wait = 1000; cfg_err_at = 0; sl_xfer_no = 0;
    exp_e.push_back('0);
    @(negedge PCLK);
    first_idx = 3'd0; last_idx = 3'd7; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    cyc = 0;
    while (!(PSEL && PENABLE) && cyc < 50) begin
      @(negedge PCLK);
      cyc++;
    end
    check("pre_rst_access", 32'(PSEL && PENABLE), 32'd1);
    #2 PRESET = 1'b1;
    #1;
    check("midrst_psel", 32'(PSEL), 32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_paddr", PADDR, 32'd0);
    check("midrst_pwdata", PWDATA, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    cfg_wait = 0;
    repeat (2) @(negedge PCLK);
    run_sweep(2, 5, 1, 0, 0, 0);   // recovery after reset

    repeat (4) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
